// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path.
// Segment bit order: bit 6 = a, bit 5 = b, ... bit 0 = g (active-high).
package seg7_pkg;

  localparam int SEG_A_BIT = 6;
  localparam int SEG_G_BIT = 0;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  // Decode-failure marker; never a legal BCD digit.
  localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder with legality flag.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal
);

  always_comb begin
    bcd = BCD_INVALID;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: bcd = BCD_INVALID;
    endcase
    legal = (bcd != BCD_INVALID);
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: debounces each scanned
// position and captures one BCD digit per stable interval.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    err,
  output logic                    frame_done
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]         CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ONE     = NUM_DIGITS'(1);

  logic [NUM_DIGITS+6:0] cur, sample_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  captured_q, captured_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_set;
  logic                  onehot, capture, frame_hit;
  logic [IW-1:0]         idx;
  logic [3:0]            dec_bcd;
  logic                  dec_legal;

  assign cur    = {dig_sel, seg_in};
  assign onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - ONE)) == '0);

  // OR of the indices of all set bits; only meaningful when onehot holds.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_sel[i]) idx = idx | IW'(i);
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    captured_d = captured_q;
    if (cur != sample_q) begin
      cnt_d      = CW'(1);
      captured_d = 1'b0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (!onehot) cnt_d = '0;
    capture = onehot && (cnt_d == CNT_MAX) && !captured_d;
    if (capture) captured_d = 1'b1;
  end

  assign mask_set  = mask_q | (ONE << idx);
  assign frame_hit = &mask_set;

  seg7_to_bcd u_dec (
    .seg   (seg_in),
    .bcd   (dec_bcd),
    .legal (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= '0;
      cnt_q       <= '0;
      captured_q  <= 1'b0;
      mask_q      <= '0;
      bcd_out     <= '0;
      digit_valid <= '0;
      err         <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      sample_q   <= cur;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      err        <= 1'b0;
      frame_done <= 1'b0;
      if (capture) begin
        if (dec_legal) begin
          bcd_out[4*idx +: 4] <= dec_bcd;
          digit_valid[idx]    <= 1'b1;
          if (frame_hit) begin
            mask_q     <= '0;
            frame_done <= 1'b1;
          end else begin
            mask_q <= mask_set;
          end
        end else begin
          err              <= 1'b1;
          digit_valid[idx] <= 1'b0;
          mask_q[idx]      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (default build plus STABLE_CYCLES=1 build).
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    seg_in = '0, seg1 = '0;
  logic [ND-1:0] dig_sel = '0, sel1 = '0;
  logic [4*ND-1:0] bcd_out, bcd1;
  logic [ND-1:0] digit_valid, vld1;
  logic          err, frame_done, err1, fd1;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .err(err), .frame_done(frame_done)
  );

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg_in(seg1), .dig_sel(sel1),
    .bcd_out(bcd1), .digit_valid(vld1), .err(err1), .frame_done(fd1)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  vld;
    logic        err;
    logic        fd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [6:0] codes [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011};

  logic [15:0] m_bcd  = '0;
  logic [3:0]  m_vld  = '0;
  logic [3:0]  m_mask = '0;
  logic [10:0] m_prev = '0;
  int          m_run  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] tb_dec(input logic [6:0] s);
    tb_dec = 5'h0F;
    for (int k = 0; k < 10; k++)
      if (codes[k] == s) tb_dec = {1'b1, 4'(k)};
  endfunction

  // Drive one position for n edges; expected outputs per edge go to the scoreboard.
  task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
    exp_t       e;
    logic [4:0] d;
    int         pos;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      dig_sel = sel;
      seg_in  = seg;
      if ({sel, seg} != m_prev) begin
        m_prev = {sel, seg};
        m_run  = 1;
      end else if (m_run < 1000) begin
        m_run++;
      end
      e.err = 1'b0;
      e.fd  = 1'b0;
      if ($countones(sel) == 1 && m_run == SC) begin
        pos = 0;
        for (int b = 0; b < ND; b++) if (sel[b]) pos = b;
        d = tb_dec(seg);
        if (d[4]) begin
          m_bcd[4*pos +: 4] = d[3:0];
          m_vld[pos]  = 1'b1;
          m_mask[pos] = 1'b1;
          if (m_mask == 4'hF) begin
            e.fd   = 1'b1;
            m_mask = '0;
          end
        end else begin
          e.err       = 1'b1;
          m_vld[pos]  = 1'b0;
          m_mask[pos] = 1'b0;
        end
      end
      e.bcd = m_bcd;
      e.vld = m_vld;
      sb.push_back(e);
    end
  endtask

  exp_t got_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      got_e = sb.pop_front();
      check("bcd_out", 32'(bcd_out), 32'(got_e.bcd));
      check("digit_valid", 32'(digit_valid), 32'(got_e.vld));
      check("err", 32'(err), 32'(got_e.err));
      check("frame_done", 32'(frame_done), 32'(got_e.fd));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    hold(4'b0001, codes[1], 4);
    hold(4'b0010, codes[2], 3);
    hold(4'b0010, codes[3], 4);

    for (int r = 0; r < 2; r++)
      for (int dgt = 0; dgt < 4; dgt++)
        hold(4'(1 << dgt), codes[9 - dgt], 5);

    hold(4'b0100, 7'b0000000, 4);
    hold(4'b0001, codes[5], 4);
    hold(4'b0010, codes[4], 4);
    hold(4'b1000, codes[2], 4);

    hold(4'b0110, codes[0], 10);
    hold(4'b0100, codes[0], 4);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3;
    rst_n   = 1'b0;
    dig_sel = '0;
    seg_in  = '0;
    #1;
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    m_bcd = '0; m_vld = '0; m_mask = '0; m_prev = '0; m_run = 0;
    @(negedge clk);
    rst_n = 1'b1;
    hold(4'b0001, codes[1], 4);
    hold(4'b0001, codes[7], 6);

    @(posedge clk);
    #2;
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      sel1 = 4'b0001;
      seg1 = codes[v];
      @(posedge clk);
      #2;
      check("sc1_nibble0", 32'(bcd1[3:0]), 32'(v));
      check("sc1_valid0", 32'(vld1[0]), 32'h1);
      check("sc1_err", 32'(err1), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
